// File: rtl/spi_leader_engine_if.sv
// CPU-side handshake bundle for spi_leader_engine: tx request/config in, rx result and status out.
// Purely combinational wiring; backpressure is carried by tx_ready.
interface spi_leader_engine_if #(
    parameter int DATA_W = 16,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8
);
    localparam int LEN_W = $clog2(DATA_W + 1);
    localparam int CSW   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              cfg_cpol;
    logic              cfg_cpha;
    logic              cfg_lsb_first;
    logic [DIV_W-1:0]  cfg_div;
    logic [LEN_W-1:0]  cfg_len;
    logic [CSW-1:0]    cfg_cs_sel;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;

    modport master (
        output tx_valid, tx_data, cfg_cpol, cfg_cpha, cfg_lsb_first, cfg_div, cfg_len, cfg_cs_sel,
        input  tx_ready, rx_data, rx_valid, busy
    );

    modport slave (
        input  tx_valid, tx_data, cfg_cpol, cfg_cpha, cfg_lsb_first, cfg_div, cfg_len, cfg_cs_sel,
        output tx_ready, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/spi_leader_engine.sv
// SPI leader: one 1..DATA_W-bit frame per accepted request; cs_n falls the cycle after accept, rx_valid at +(2*len+1)*H.
// Backpressure: tx_ready low from accept until the rx_valid cycle; requests arriving while busy are not queued.
module spi_leader_engine #(
    parameter int DATA_W = 16,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    spi_leader_engine_if.slave bus,
    output logic               sclk,
    output logic               mosi,
    input  logic               miso,
    output logic [NUM_CS-1:0]  cs_n
);
    localparam int LEN_W = $clog2(DATA_W + 1);
    localparam int CSW   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int EW    = LEN_W + 1;

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    typedef struct packed {
        logic             cpol;
        logic             cpha;
        logic             lsb_first;
        logic [DIV_W-1:0] div;
        logic [LEN_W-1:0] len;
    } cfg_t;

    state_t            state;
    cfg_t              cfg;
    logic [DIV_W-1:0]  cnt;
    logic [EW-1:0]     edge_cnt;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;

    logic              accept;
    logic [LEN_W-1:0]  len_eff;
    logic [LEN_W-1:0]  tx_pad;
    logic [LEN_W-1:0]  rx_pad;
    logic [DATA_W-1:0] tx_aligned;
    logic              tx_first;
    logic              tx_head;
    logic [NUM_CS-1:0] cs_dec;
    logic [EW-1:0]     edge_nxt;
    logic              sample_edge;
    logic              last_edge;

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    assign accept  = (state == IDLE) && bus.tx_valid && bus.tx_ready;
    assign len_eff = (bus.cfg_len == '0 || bus.cfg_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : bus.cfg_len;
    assign tx_pad  = LEN_W'(DATA_W) - len_eff;
    assign rx_pad  = LEN_W'(DATA_W) - cfg.len;

    // MSB-first payloads are pre-shifted so the first bit always sits at the top of the shifter.
    assign tx_aligned = bus.cfg_lsb_first ? bus.tx_data : (bus.tx_data << tx_pad);
    assign tx_first   = bus.cfg_lsb_first ? tx_aligned[0] : tx_aligned[DATA_W-1];
    assign tx_head    = cfg.lsb_first ? tx_sr[0] : tx_sr[DATA_W-1];

    assign edge_nxt    = edge_cnt + 1'b1;
    assign sample_edge = cfg.cpha ? ~edge_nxt[0] : edge_nxt[0];
    assign last_edge   = (edge_nxt == {cfg.len, 1'b0});

    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (bus.cfg_cs_sel == CSW'(i)) cs_dec[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cfg          <= '0;
            cnt          <= '0;
            edge_cnt     <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            bus.tx_ready <= 1'b0;
            bus.busy     <= 1'b0;
            bus.rx_valid <= 1'b0;
            bus.rx_data  <= '0;
            sclk         <= 1'b0;
            mosi         <= 1'b0;
            cs_n         <= '1;
        end else begin
            bus.rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    bus.tx_ready <= 1'b1;
                    if (accept) begin
                        state         <= SETUP;
                        cfg.cpol      <= bus.cfg_cpol;
                        cfg.cpha      <= bus.cfg_cpha;
                        cfg.lsb_first <= bus.cfg_lsb_first;
                        cfg.div       <= bus.cfg_div;
                        cfg.len       <= len_eff;
                        cnt           <= bus.cfg_div;
                        edge_cnt      <= '0;
                        rx_sr         <= '0;
                        bus.tx_ready  <= 1'b0;
                        bus.busy      <= 1'b1;
                        sclk          <= bus.cfg_cpol;
                        cs_n          <= cs_dec;
                        if (bus.cfg_cpha) begin
                            mosi  <= 1'b0;
                            tx_sr <= tx_aligned;
                        end else begin
                            mosi  <= tx_first;
                            tx_sr <= advance(tx_aligned, bus.cfg_lsb_first);
                        end
                    end
                end
                SETUP, XFER: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt      <= cfg.div;
                        sclk     <= ~sclk;
                        edge_cnt <= edge_nxt;
                        state    <= last_edge ? HOLD : XFER;
                        if (sample_edge) begin
                            rx_sr <= cfg.lsb_first ? {miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso};
                        end else if (!last_edge) begin
                            // With CPHA=0 the final trailing edge has no bit left to drive.
                            mosi  <= tx_head;
                            tx_sr <= advance(tx_sr, cfg.lsb_first);
                        end
                    end
                end
                HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state        <= IDLE;
                        cs_n         <= '1;
                        bus.rx_data  <= cfg.lsb_first ? (rx_sr >> rx_pad) : rx_sr;
                        bus.rx_valid <= 1'b1;
                        bus.tx_ready <= 1'b1;
                        bus.busy     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
